min_sec_countdown: RTL and testbench
====================================

// Module: min_sec_countdown
// PURPOSE
//   BCD minutes:seconds countdown timer, 99:59 down to 00:00. Down-counting counterpart of the up-counting minute/second counters.
//   Loaded with a BCD preset, decrements once per tick strobe, and flags expiry.
//   Drives the same MH/ML/SH/SL digit bus that the display path already consumes.
// PARAMETERS
//   MIN_MAX_H  9  max preset minutes-tens digit (higher presets are not legal)
//   SEC_MAX_H  5  seconds-tens wrap value on borrow
// PORTS
//   clk      in   1  system clock, rising edge
//   reset    in   1  synchronous, active-high
//   tick     in   1  one-cycle 1 Hz enable strobe
//   load     in   1  latch preset digits into the counter
//   pre_mh   in   4  preset minutes tens (BCD)
//   pre_ml   in   4  preset minutes units (BCD)
//   pre_sh   in   4  preset seconds tens (BCD)
//   pre_sl   in   4  preset seconds units (BCD)
//   en       in   1  level: 1 = count, 0 = hold
//   MH,ML    out  4  current minutes digits (BCD)
//   SH,SL    out  4  current seconds digits (BCD)
//   running  out  1  high in RUN state
//   done     out  1  one-cycle pulse on reaching 00:00
// BEHAVIOUR
//   Reset (sync, active-high): all digits 0, state IDLE, running=0, done=0.
//   Priority each cycle: reset > load > state/en update > tick decrement.
//   States: IDLE -(en=1, count!=0)-> RUN; IDLE -(en=1, count==0)-> DONE + done pulse.
//     RUN -(en=0)-> HOLD; HOLD -(en=1)-> RUN.
//     RUN -(tick, decrement yields 00:00)-> DONE.
//     DONE -(load)-> IDLE; DONE ignores tick and en.
//   load in any state: digits <= preset, state <= IDLE, done=0. Same-cycle tick is dropped.
//   Decrement on tick in RUN only. Registered: digits change the cycle after the tick edge.
//     SL 0->9 with borrow, else SL-1. SH 0->SEC_MAX_H on borrow. ML 0->9 on borrow.
//     MH decrements on borrow. 00:00 is never decremented.
//   done is asserted in the same registered cycle that the digits become 00:00 (or on the
//     IDLE->DONE zero-start). It is deasserted the following cycle.
//   HOLD: digits frozen, ticks ignored, running=0.
//   Digits stay valid BCD at all times given legal presets. Illegal presets are handled
//     per CONFIGURATION.
// CONFIGURATION
//   LOAD_CLAMP_EN defined: on load, any preset digit >9 is forced to 9, and pre_sh >5 is forced to SEC_MAX_H.
//   LOAD_CLAMP_EN undefined: presets are loaded verbatim. Behaviour with non-BCD digits is
//     undefined, and the bench must not drive them.
// STRUCTURE
//   Package min_sec_pkg: state enum {IDLE,RUN,HOLD,DONE}, localparams DIG_MAX=4'd9, SEC_MAX_H default.
//   Sub-module bcd_digit_down (param WRAP): 4-bit digit with dec_in and borrow_out.
//     borrow_out = dec_in & (digit==0). Four instances are chained SL->SH->ML->MH.
//   Top holds the FSM, load muxing, the zero detect, and the done register.
// TESTING
//   1 load 01:00, en=1, 1 tick -> 00:59 next cycle, running=1, done=0.
//   2 load 00:02, en=1, 2 ticks -> 00:01 then 00:00 with done=1 for exactly one cycle.
//     3rd tick -> no change, state DONE.
//   3 load 10:00, 1 tick -> 09:59 (full borrow chain). Load 99:59 -> digits 9,9,5,9.
//   4 RUN at 00:30, drop en, 5 ticks -> stays 00:30, running=0.
//     Raise en, 1 tick -> 00:29.
//   5 load and tick in the same cycle at 05:00 -> 05:00 loaded, no decrement.
//     Load during RUN -> IDLE. Reset mid-RUN -> 00:00, done=0.
//   6 load 00:00, en=1 -> done pulse next cycle. With LOAD_CLAMP_EN, preset sh=7, sl=12 -> 5,9.

Source files
------------

// File: rtl/min_sec_pkg.sv
// Shared types and constants for the BCD minutes:seconds countdown timer.
// The clamp helper is only used when LOAD_CLAMP_EN is defined.
package min_sec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [3:0] DIG_MAX       = 4'd9;
    localparam logic [3:0] MIN_MAX_H_DEF = 4'd9;
    localparam logic [3:0] SEC_MAX_H_DEF = 4'd5;

    // Saturate a preset digit to the largest value legal in its position.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_val);
        return (d > max_val) ? max_val : d;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit. It wraps to WRAP when decremented at zero
// and raises borrow_out so the next more-significant digit steps down.
module bcd_digit_down #(
    parameter logic [3:0] WRAP = 4'd9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec_in,
    output logic [3:0] digit,
    output logic       borrow_out
);

    logic [3:0] digit_d;
    logic [3:0] digit_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_val;
        end else if (dec_in) begin
            digit_d = (digit_q == 4'd0) ? WRAP : digit_q - 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign borrow_out = dec_in & (digit_q == 4'd0);

endmodule

// File: rtl/min_sec_countdown.sv
// BCD minutes:seconds countdown timer (99:59 .. 00:00) with run/hold/done control.
// Define LOAD_CLAMP_EN to saturate out-of-range preset digits on load.
module min_sec_countdown
    import min_sec_pkg::*;
#(
    parameter logic [3:0] MIN_MAX_H = MIN_MAX_H_DEF,
    parameter logic [3:0] SEC_MAX_H = SEC_MAX_H_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] pre_mh,
    input  logic [3:0] pre_ml,
    input  logic [3:0] pre_sh,
    input  logic [3:0] pre_sl,
    input  logic       en,
    output logic [3:0] MH,
    output logic [3:0] ML,
    output logic [3:0] SH,
    output logic [3:0] SL,
    output logic       running,
    output logic       done
);

    state_e     state_d, state_q;
    logic       done_d, done_q;
    logic [3:0] ld_mh, ld_ml, ld_sh, ld_sl;
    logic [4:0] borrow;
    logic       count_zero;
    logic       last_step;
    logic       dec_en;

`ifdef LOAD_CLAMP_EN
    assign ld_mh = clamp_digit(pre_mh, MIN_MAX_H);
    assign ld_ml = clamp_digit(pre_ml, DIG_MAX);
    assign ld_sh = clamp_digit(pre_sh, SEC_MAX_H);
    assign ld_sl = clamp_digit(pre_sl, DIG_MAX);
`else
    assign ld_mh = pre_mh;
    assign ld_ml = pre_ml;
    assign ld_sh = pre_sh;
    assign ld_sl = pre_sl;
`endif

    assign count_zero = ({MH, ML, SH, SL} == 16'h0000);
    assign last_step  = ({MH, ML, SH} == 12'h000) && (SL == 4'd1);
    assign dec_en     = !load && (state_q == RUN) && en && tick && !count_zero;
    assign borrow[0]  = dec_en;

    bcd_digit_down #(.WRAP(DIG_MAX)) u_sl (
        .clk(clk), .reset(reset), .load(load), .load_val(ld_sl),
        .dec_in(borrow[0]), .digit(SL), .borrow_out(borrow[1])
    );

    bcd_digit_down #(.WRAP(SEC_MAX_H)) u_sh (
        .clk(clk), .reset(reset), .load(load), .load_val(ld_sh),
        .dec_in(borrow[1]), .digit(SH), .borrow_out(borrow[2])
    );

    bcd_digit_down #(.WRAP(DIG_MAX)) u_ml (
        .clk(clk), .reset(reset), .load(load), .load_val(ld_ml),
        .dec_in(borrow[2]), .digit(ML), .borrow_out(borrow[3])
    );

    bcd_digit_down #(.WRAP(MIN_MAX_H)) u_mh (
        .clk(clk), .reset(reset), .load(load), .load_val(ld_mh),
        .dec_in(borrow[3]), .digit(MH), .borrow_out(borrow[4])
    );

    // A borrow out of MH cannot occur from a legal count; treat it as terminal anyway.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        if (count_zero) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (!en) begin
                        state_d = HOLD;
                    end else if (dec_en && (last_step || borrow[4])) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                HOLD: begin
                    if (en) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign running = (state_q == RUN);
    assign done    = done_q;

endmodule

// File: tb/tb_min_sec_countdown.sv
// Self-checking bench for min_sec_countdown: directed scenarios plus random traffic
// against a seconds-based reference model.
module tb_min_sec_countdown;

    logic       clk = 1'b0;
    logic       reset, tick, load, en;
    logic [3:0] pre_mh, pre_ml, pre_sh, pre_sl;
    logic [3:0] MH, ML, SH, SL;
    logic       running, done;

    int checks = 0;
    int errors = 0;

    typedef enum {PH_IDLE, PH_RUN, PH_HOLD, PH_FIN} phase_t;
    phase_t m_phase;
    int     m_secs;
    logic   m_done;

    min_sec_countdown dut (
        .clk(clk), .reset(reset), .tick(tick), .load(load),
        .pre_mh(pre_mh), .pre_ml(pre_ml), .pre_sh(pre_sh), .pre_sl(pre_sl),
        .en(en), .MH(MH), .ML(ML), .SH(SH), .SL(SL),
        .running(running), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] clamp4(input logic [3:0] d, input logic [3:0] mx);
        return (d > mx) ? mx : d;
    endfunction

    function automatic logic [15:0] secs_to_bcd(input int secs);
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // Reference: the count is a plain number of seconds; decrementing is subtraction.
    task automatic model_update();
        logic [3:0] mh, ml, sh, sl;
        mh = pre_mh; ml = pre_ml; sh = pre_sh; sl = pre_sl;
`ifdef LOAD_CLAMP_EN
        mh = clamp4(mh, 4'd9); ml = clamp4(ml, 4'd9);
        sh = clamp4(sh, 4'd5); sl = clamp4(sl, 4'd9);
`endif
        m_done = 1'b0;
        if (reset) begin
            m_secs  = 0;
            m_phase = PH_IDLE;
        end else if (load) begin
            m_secs  = (int'(mh) * 10 + int'(ml)) * 60 + int'(sh) * 10 + int'(sl);
            m_phase = PH_IDLE;
        end else begin
            case (m_phase)
                PH_IDLE: if (en) begin
                    if (m_secs == 0) begin m_phase = PH_FIN; m_done = 1'b1; end
                    else m_phase = PH_RUN;
                end
                PH_RUN: if (!en) m_phase = PH_HOLD;
                    else if (tick && m_secs > 0) begin
                        m_secs = m_secs - 1;
                        if (m_secs == 0) begin m_phase = PH_FIN; m_done = 1'b1; end
                    end
                PH_HOLD: if (en) m_phase = PH_RUN;
                default: ;
            endcase
        end
    endtask

    // One clock with current inputs, then compare every output with the model.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            model_update();
            @(posedge clk);
            #1;
            check("digits", {MH, ML, SH, SL}, secs_to_bcd(m_secs));
            check("running", 16'(running), 16'(m_phase == PH_RUN));
            check("done", 16'(done), 16'(m_done));
        end
    endtask

    task automatic do_load(input logic [3:0] mh, ml, sh, sl);
        pre_mh = mh; pre_ml = ml; pre_sh = sh; pre_sl = sl;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; load = 1'b0; en = 1'b0;
        pre_mh = 4'd0; pre_ml = 4'd0; pre_sh = 4'd0; pre_sl = 4'd0;
        m_secs = 0; m_phase = PH_IDLE; m_done = 1'b0;
        #2;
        step(2);
        check("reset_digits", {MH, ML, SH, SL}, 16'h0000);
        check("reset_running", 16'(running), 16'h0);
        check("reset_done", 16'(done), 16'h0);
        reset = 1'b0;
        step();

        // 01:00 -> 00:59 on first tick
        do_load(4'd0, 4'd1, 4'd0, 4'd0);
        en = 1'b1;
        step();
        do_tick();
        check("t1_digits", {MH, ML, SH, SL}, 16'h0059);
        check("t1_running", 16'(running), 16'h1);
        check("t1_done", 16'(done), 16'h0);

        // 00:02 -> 00:01 -> 00:00 with a single-cycle done pulse
        do_load(4'd0, 4'd0, 4'd0, 4'd2);
        step();
        do_tick();
        check("t2_first", {MH, ML, SH, SL}, 16'h0001);
        do_tick();
        check("t2_zero", {MH, ML, SH, SL}, 16'h0000);
        check("t2_done_hi", 16'(done), 16'h1);
        step();
        check("t2_done_lo", 16'(done), 16'h0);
        do_tick();
        check("t2_after_done", {MH, ML, SH, SL}, 16'h0000);
        check("t2_after_run", 16'(running), 16'h0);
        check("t2_after_pulse", 16'(done), 16'h0);

        // Full borrow chain and maximum preset
        do_load(4'd1, 4'd0, 4'd0, 4'd0);
        step();
        do_tick();
        check("t3_chain", {MH, ML, SH, SL}, 16'h0959);
        do_load(4'd9, 4'd9, 4'd5, 4'd9);
        check("t3_max", {MH, ML, SH, SL}, 16'h9959);

        // Hold freezes digits and ignores ticks
        do_load(4'd0, 4'd0, 4'd3, 4'd1);
        step();
        do_tick();
        en = 1'b0;
        step();
        tick = 1'b1;
        step(5);
        tick = 1'b0;
        check("t4_hold", {MH, ML, SH, SL}, 16'h0030);
        check("t4_hold_run", 16'(running), 16'h0);
        en = 1'b1;
        step();
        do_tick();
        check("t4_resume", {MH, ML, SH, SL}, 16'h0029);

        // Load beats a same-cycle tick; load during RUN; reset mid-RUN
        pre_mh = 4'd0; pre_ml = 4'd5; pre_sh = 4'd0; pre_sl = 4'd0;
        load = 1'b1; tick = 1'b1;
        step();
        load = 1'b0; tick = 1'b0;
        check("t5_load_tick", {MH, ML, SH, SL}, 16'h0500);
        step();
        do_tick();
        check("t5_run", {MH, ML, SH, SL}, 16'h0459);
        do_load(4'd0, 4'd3, 4'd0, 4'd0);
        check("t5_load_idle", 16'(running), 16'h0);
        step();
        do_tick();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_reset", {MH, ML, SH, SL}, 16'h0000);
        check("t5_reset_done", 16'(done), 16'h0);

        // Zero-start goes straight to DONE with a pulse
        do_load(4'd0, 4'd0, 4'd0, 4'd0);
        step();
        check("t6_zero_done", 16'(done), 16'h1);
        step();
        check("t6_zero_done_lo", 16'(done), 16'h0);
`ifdef LOAD_CLAMP_EN
        do_load(4'd12, 4'd11, 4'd7, 4'd12);
        check("t6_clamp", {MH, ML, SH, SL}, 16'h9959);
`endif

        // Random traffic with short legal presets so expiry is reached often
        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom_range(0, 199) == 0);
            load   = ($urandom_range(0, 39) == 0);
            pre_mh = 4'd0;
            pre_ml = 4'($urandom_range(0, 1));
            pre_sh = 4'($urandom_range(0, 5));
            pre_sl = 4'($urandom_range(0, 9));
            en     = ($urandom_range(0, 9) != 0);
            tick   = ($urandom_range(0, 1) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
